// File: rtl/logic16_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the result consumer.
interface logic16_arbiter_if #(
   parameter int unsigned WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;

   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_out;

   logic [15:0]      grant_count;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_out,
      input  rsp_ready,
      output grant_count
   );

   // Requester / consumer side.
   modport master (
      output req0_valid, req0_op, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_out,
      output rsp_ready,
      input  grant_count
   );
endinterface

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter for two requesters sharing one 16-bit bitwise logic unit.
// A single result slot holds the registered, id-tagged result until consumed.
module logic16_arbiter #(
   parameter int unsigned WIDTH = 16
) (
   input logic              clk,
   input logic              rst_n,
   logic16_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state;
   logic               last_grant;
   logic [WIDTH-1:0]   rsp_out;
   logic               rsp_id;
   logic [CNT_W-1:0]   grant_count;

   logic               slot_free;
   logic               win0;
   logic               win1;
   logic               accept;
   logic               winner;
   logic [1:0]         sel_op;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;
   logic [WIDTH-1:0]   result;

   // Winner selection: a lone requester wins, a tie goes to the one not granted last.
   always_comb begin
      slot_free = (state == EMPTY) || bus.rsp_ready;
      win0      = bus.req0_valid && (!bus.req1_valid || last_grant);
      win1      = bus.req1_valid && (!bus.req0_valid || !last_grant);
      accept    = rst_n && slot_free && (win0 || win1);
      winner    = win1;
   end

   // Operand mux and shared bitwise unit.
   always_comb begin
      sel_op = winner ? bus.req1_op : bus.req0_op;
      sel_a  = winner ? bus.req1_a  : bus.req0_a;
      sel_b  = winner ? bus.req1_b  : bus.req0_b;
      case (sel_op)
         OP_AND:  result = sel_a & sel_b;
         OP_OR:   result = sel_a | sel_b;
         OP_XOR:  result = sel_a ^ sel_b;
         default: result = ~(sel_a & sel_b);
      endcase
   end

   // Slot state, result register, round-robin pointer and grant counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         rsp_out     <= '0;
         rsp_id      <= 1'b0;
         last_grant  <= 1'b1;
         grant_count <= '0;
      end else if (accept) begin
         state       <= FULL;
         rsp_out     <= result;
         rsp_id      <= winner;
         last_grant  <= winner;
         grant_count <= grant_count + CNT_W'(1);
      end else if ((state == FULL) && bus.rsp_ready) begin
         state <= EMPTY;
      end
   end

   assign bus.req0_ready  = accept && !winner;
   assign bus.req1_ready  = accept && winner;
   assign bus.rsp_valid   = (state == FULL);
   assign bus.rsp_id      = rsp_id;
   assign bus.rsp_out     = rsp_out;
   assign bus.grant_count = grant_count;
endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed bench for logic16_arbiter: reset, ops, fairness, backpressure, mid-run reset, wrap.
module tb_logic16_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic16_arbiter_if #(.WIDTH(16)) bus ();

   logic16_arbiter #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] sweep_exp [0:3];
      sweep_exp[0] = 16'h0000;
      sweep_exp[1] = 16'hFFFF;
      sweep_exp[2] = 16'hFFFF;
      sweep_exp[3] = 16'hFFFF;
      checks = 0;
      errors = 0;

      rst_n          = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req0_op    = 2'b00;
      bus.req0_a     = 16'hFFFF;
      bus.req0_b     = 16'hFFFF;
      bus.req1_valid = 1'b1;
      bus.req1_op    = 2'b00;
      bus.req1_a     = 16'h0000;
      bus.req1_b     = 16'h0000;
      bus.rsp_ready  = 1'b1;
      #3;
      chk("rst_ready0", 32'(bus.req0_ready), 32'h0);
      chk("rst_ready1", 32'(bus.req1_ready), 32'h0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_out", 32'(bus.rsp_out), 32'h0);
      chk("rst_id", 32'(bus.rsp_id), 32'h0);
      chk("rst_count", 32'(bus.grant_count), 32'h0);

      // req0 alone: AND of FFFF,FFFF
      tick();
      bus.req1_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      chk("solo_ready0", 32'(bus.req0_ready), 32'h1);
      chk("solo_ready1", 32'(bus.req1_ready), 32'h0);
      tick();
      bus.req0_valid = 1'b0;
      #1;
      chk("solo_valid", 32'(bus.rsp_valid), 32'h1);
      chk("solo_id", 32'(bus.rsp_id), 32'h0);
      chk("solo_out", 32'(bus.rsp_out), 32'hFFFF);
      chk("solo_count", 32'(bus.grant_count), 32'h1);
      chk("solo_noready", 32'(bus.req0_ready), 32'h0);

      // Op sweep on req1
      bus.req1_valid = 1'b1;
      bus.req1_a = 16'hA5A5;
      bus.req1_b = 16'h5A5A;
      for (int i = 0; i < 4; i++) begin
         bus.req1_op = 2'(i);
         #1;
         chk("sweep_ready1", 32'(bus.req1_ready), 32'h1);
         tick();
         chk("sweep_out", 32'(bus.rsp_out), 32'(sweep_exp[i]));
         chk("sweep_id", 32'(bus.rsp_id), 32'h1);
      end
      bus.req1_op = 2'b00;
      bus.req1_a  = 16'h0000;
      bus.req1_b  = 16'hFFFF;
      tick();
      chk("and_zero_out", 32'(bus.rsp_out), 32'h0000);
      chk("and_zero_id", 32'(bus.rsp_id), 32'h1);
      chk("sweep_count", 32'(bus.grant_count), 32'h6);
      bus.req1_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(bus.rsp_valid), 32'h0);

      // Fairness with both valid: 0,1,0,1,0,1
      bus.req0_valid = 1'b1;
      bus.req0_op = 2'b01;
      bus.req0_a  = 16'h00F0;
      bus.req0_b  = 16'h0F00;
      bus.req1_valid = 1'b1;
      bus.req1_op = 2'b10;
      bus.req1_a  = 16'hFF00;
      bus.req1_b  = 16'h0FF0;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_ready0", 32'(bus.req0_ready), 32'((i % 2) == 0));
         chk("rr_ready1", 32'(bus.req1_ready), 32'((i % 2) == 1));
         tick();
         chk("rr_valid", 32'(bus.rsp_valid), 32'h1);
         chk("rr_id", 32'(bus.rsp_id), 32'(i % 2));
         chk("rr_out", 32'(bus.rsp_out), ((i % 2) == 0) ? 32'h0FF0 : 32'hF0F0);
      end
      chk("rr_count", 32'(bus.grant_count), 32'd12);

      // Backpressure: held result stays, nobody is granted
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready0", 32'(bus.req0_ready), 32'h0);
         chk("bp_ready1", 32'(bus.req1_ready), 32'h0);
         tick();
         chk("bp_out", 32'(bus.rsp_out), 32'hF0F0);
         chk("bp_id", 32'(bus.rsp_id), 32'h1);
         chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
         chk("bp_count", 32'(bus.grant_count), 32'd12);
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready0", 32'(bus.req0_ready), 32'h1);
      tick();
      chk("bp_release_out", 32'(bus.rsp_out), 32'h0FF0);
      chk("bp_release_id", 32'(bus.rsp_id), 32'h0);
      chk("bp_release_count", 32'(bus.grant_count), 32'd13);

      // Asynchronous reset while holding 1234
      bus.req1_valid = 1'b0;
      bus.req0_a = 16'h1200;
      bus.req0_b = 16'h0034;
      tick();
      chk("pre_rst_out", 32'(bus.rsp_out), 32'h1234);
      chk("pre_rst_count", 32'(bus.grant_count), 32'd14);
      bus.rsp_ready  = 1'b0;
      bus.req0_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.rsp_valid), 32'h0);
      chk("arst_out", 32'(bus.rsp_out), 32'h0);
      chk("arst_id", 32'(bus.rsp_id), 32'h0);
      chk("arst_count", 32'(bus.grant_count), 32'h0);
      bus.req0_valid = 1'b1;
      bus.req0_a = 16'h00F0;
      bus.req0_b = 16'h0F00;
      bus.req1_valid = 1'b1;
      bus.rsp_ready  = 1'b1;
      #1;
      chk("arst_ready0", 32'(bus.req0_ready), 32'h0);
      chk("arst_ready1", 32'(bus.req1_ready), 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("tie_ready0", 32'(bus.req0_ready), 32'h1);
      chk("tie_ready1", 32'(bus.req1_ready), 32'h0);
      tick();
      chk("tie_id", 32'(bus.rsp_id), 32'h0);
      chk("tie_out", 32'(bus.rsp_out), 32'h0FF0);
      chk("tie_count", 32'(bus.grant_count), 32'h1);

      // Wrap: 65535 more grants bring the counter back to zero
      repeat (65535) tick();
      chk("wrap_count", 32'(bus.grant_count), 32'h0);
      chk("wrap_id", 32'(bus.rsp_id), 32'h1);
      chk("wrap_out", 32'(bus.rsp_out), 32'hF0F0);
      chk("wrap_ready0", 32'(bus.req0_ready), 32'h1);
      tick();
      chk("post_wrap_count", 32'(bus.grant_count), 32'h1);
      chk("post_wrap_id", 32'(bus.rsp_id), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
